// File: rtl/sdram_arb_pkg.sv
// Shared constants for the SDRAM port arbiter: slot layout, FSM encoding, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arb_pkg;

  // Slot 2i is master i's write channel, slot 2i+1 its read-address channel
  localparam int SLOT_WR = 0;
  localparam int SLOT_RD = 1;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Default controller address/data widths
  localparam int DEF_AW = 24;
  localparam int DEF_DW = 16;

  // Index width for n entries, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arb_idfifo.sv
// In-order FIFO of master IDs for reads that are in flight at the controller.
// Latency: head_id reflects a push on the following cycle; pop takes effect at the clock edge.
// Backpressure: none internally; the parent never pushes while full (read slots go ineligible).
module sdram_arb_idfifo
  import sdram_arb_pkg::*;
#(
  parameter int IDW   = 1,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  logic [IDW-1:0] i_push_id,
  input  logic           i_pop,
  output logic [IDW-1:0] o_head_id,
  output logic           o_empty,
  output logic           o_full
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IDW-1:0] r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  // Pointers wrap at DEPTH explicitly so a single-entry FIFO also works
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; simultaneous push/pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_id;
  end

  assign o_head_id = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin sharing of the SDRAM controller request port between NM masters; read data steered back in order.
// Latency: request forwarded 1 cycle after IDLE sees it; at most one request every 2 cycles.
// Backpressure: controller readies routed only to the granted master; read return stalls on the owning master's ready.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NM       = 2,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int RD_OUTST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM*DW-1:0] m_wr_data,
  input  logic [NM*AW-1:0] m_wr_addr,
  input  logic [NM-1:0]    m_wr_valid,
  output logic [NM-1:0]    m_wr_ready,
  input  logic [NM*AW-1:0] m_rd_addr,
  input  logic [NM-1:0]    m_rd_avalid,
  output logic [NM-1:0]    m_rd_aready,
  output logic [NM*DW-1:0] m_rd_data,
  output logic [NM-1:0]    m_rd_valid,
  input  logic [NM-1:0]    m_rd_ready,
  output logic [DW-1:0]    c_wr_data,
  output logic [AW-1:0]    c_wr_addr,
  output logic             c_wr_valid,
  input  logic             c_wr_ready,
  output logic [AW-1:0]    c_rd_addr,
  output logic             c_rd_avalid,
  input  logic             c_rd_aready,
  input  logic [DW-1:0]    c_rd_data,
  input  logic             c_rd_valid,
  output logic             c_rd_ready,
  input  logic             sdram_init_done,
  output logic             arb_busy,
  output logic             err_orphan
);

  localparam int NS  = 2 * NM;
  localparam int SW  = clog2_min1(NS);
  localparam int IDW = clog2_min1(NM);

  logic [0:0]     r_state;
  logic [SW-1:0]  r_gnt;
  logic [SW-1:0]  r_rr_ptr;
  logic           r_err_orphan;

  logic [NS-1:0]  w_elig;
  logic           w_found;
  logic [SW-1:0]  w_sel;
  logic           w_in_grant;
  logic           w_gnt_rd;
  logic [IDW-1:0] w_gnt_m;
  logic           w_gnt_vld;
  logic           w_hs;
  logic           w_push;
  logic           w_pop;
  logic [IDW-1:0] w_head_id;
  logic           w_fifo_empty;
  logic           w_fifo_full;
  logic [SW-1:0]  w_rr_next;

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_gnt_rd   = r_gnt[0];
  assign w_gnt_m    = IDW'(r_gnt >> 1);
  assign w_rr_next  = (r_gnt == SW'(NS - 1)) ? '0 : r_gnt + 1'b1;

  // Slot eligibility; reads stop competing once the ID FIFO cannot take another entry
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NM; i++) begin
      w_elig[2*i+SLOT_WR] = sdram_init_done & m_wr_valid[i];
      w_elig[2*i+SLOT_RD] = sdram_init_done & m_rd_avalid[i] & ~w_fifo_full;
    end
  end

  // First eligible slot searching cyclically from rr_ptr
  always_comb begin
    logic [SW:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NS; k++) begin
      idx = {1'b0, r_rr_ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(NS)) idx = idx - (SW+1)'(NS);
      if (!w_found && w_elig[idx[SW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = idx[SW-1:0];
      end
    end
  end

  // Forward the granted slot to the controller and return its ready to that master only
  always_comb begin
    c_wr_valid  = 1'b0;
    c_wr_addr   = '0;
    c_wr_data   = '0;
    c_rd_avalid = 1'b0;
    c_rd_addr   = '0;
    m_wr_ready  = '0;
    m_rd_aready = '0;
    if (w_in_grant) begin
      for (int i = 0; i < NM; i++) begin
        if (w_gnt_m == IDW'(i)) begin
          if (!w_gnt_rd) begin
            c_wr_valid    = m_wr_valid[i];
            c_wr_addr     = m_wr_addr[i*AW +: AW];
            c_wr_data     = m_wr_data[i*DW +: DW];
            m_wr_ready[i] = c_wr_ready;
          end else begin
            c_rd_avalid    = m_rd_avalid[i];
            c_rd_addr      = m_rd_addr[i*AW +: AW];
            m_rd_aready[i] = c_rd_aready;
          end
        end
      end
    end
  end

  assign w_gnt_vld = w_gnt_rd ? c_rd_avalid : c_wr_valid;
  assign w_hs      = w_in_grant & (w_gnt_rd ? (c_rd_avalid & c_rd_aready)
                                            : (c_wr_valid & c_wr_ready));
  assign w_push    = w_hs & w_gnt_rd;

  // Steer returning data to the FIFO head; with nothing outstanding, sink it
  always_comb begin
    m_rd_valid = '0;
    c_rd_ready = 1'b1;
    if (!w_fifo_empty) begin
      c_rd_ready = 1'b0;
      for (int i = 0; i < NM; i++) begin
        if (w_head_id == IDW'(i)) begin
          m_rd_valid[i] = c_rd_valid;
          c_rd_ready    = m_rd_ready[i];
        end
      end
    end
  end

  assign m_rd_data = {NM{c_rd_data}};
  assign w_pop     = ~w_fifo_empty & c_rd_valid & c_rd_ready;

  // Grant FSM: IDLE picks a slot, GRANT holds it until handshake or the request is withdrawn
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_found) begin
        r_gnt   <= w_sel;
        r_state <= ST_GRANT;
      end
    end else begin
      if (w_hs) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= w_rr_next;
      end else if (!w_gnt_vld) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Sticky flag for read data arriving with no read outstanding
  always_ff @(posedge clk) begin
    if (rst)                              r_err_orphan <= 1'b0;
    else if (w_fifo_empty && c_rd_valid)  r_err_orphan <= 1'b1;
  end

  assign arb_busy   = w_in_grant;
  assign err_orphan = r_err_orphan;

  sdram_arb_idfifo #(
    .IDW   (IDW),
    .DEPTH (RD_OUTST)
  ) u_idfifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_id (w_gnt_m),
    .i_pop     (w_pop),
    .o_head_id (w_head_id),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb with a read-return scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_port_arb;

  localparam int NM = 2;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RD_OUTST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM*DW-1:0] m_wr_data;
  logic [NM*AW-1:0] m_wr_addr;
  logic [NM-1:0]    m_wr_valid;
  logic [NM-1:0]    m_wr_ready;
  logic [NM*AW-1:0] m_rd_addr;
  logic [NM-1:0]    m_rd_avalid;
  logic [NM-1:0]    m_rd_aready;
  logic [NM*DW-1:0] m_rd_data;
  logic [NM-1:0]    m_rd_valid;
  logic [NM-1:0]    m_rd_ready;
  logic [DW-1:0]    c_wr_data;
  logic [AW-1:0]    c_wr_addr;
  logic             c_wr_valid;
  logic             c_wr_ready;
  logic [AW-1:0]    c_rd_addr;
  logic             c_rd_avalid;
  logic             c_rd_aready;
  logic [DW-1:0]    c_rd_data;
  logic             c_rd_valid;
  logic             c_rd_ready;
  logic             sdram_init_done;
  logic             arb_busy;
  logic             err_orphan;

  always #5 clk = ~clk;

  sdram_port_arb #(.NM(NM), .AW(AW), .DW(DW), .RD_OUTST(RD_OUTST)) dut (
    .clk(clk), .rst(rst),
    .m_wr_data(m_wr_data), .m_wr_addr(m_wr_addr), .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_rd_addr(m_rd_addr), .m_rd_avalid(m_rd_avalid), .m_rd_aready(m_rd_aready),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
    .c_wr_data(c_wr_data), .c_wr_addr(c_wr_addr), .c_wr_valid(c_wr_valid), .c_wr_ready(c_wr_ready),
    .c_rd_addr(c_rd_addr), .c_rd_avalid(c_rd_avalid), .c_rd_aready(c_rd_aready),
    .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid), .c_rd_ready(c_rd_ready),
    .sdram_init_done(sdram_init_done), .arb_busy(arb_busy), .err_orphan(err_orphan)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NM-1:0] vld;
    logic [DW-1:0] dat;
  } rexp_t;

  rexp_t         sb_q[$];
  logic [DW-1:0] ret_q[$];
  int            slot_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m_wr_valid  = '0;
    m_rd_avalid = '0;
    m_rd_ready  = '0;
    c_wr_ready  = 1'b0;
    c_rd_aready = 1'b0;
    c_rd_valid  = 1'b0;
    c_rd_data   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sdram_init_done = 1'b0;
    idle_inputs();
    sb_q.delete();
    ret_q.delete();
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Master m issues a read; expected return is queued at issue time
  task automatic issue_rd(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] dat, input string tag);
    logic found;
    rexp_t e;
    found = 1'b0;
    m_rd_addr[m*AW +: AW] = addr;
    m_rd_avalid[m] = 1'b1;
    c_rd_aready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      if (c_rd_avalid && m_rd_aready[m]) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_granted"}, 32'(found), 32'(1));
    chk({tag, "_addr"}, 32'(c_rd_addr), 32'(addr));
    e.vld = NM'(1) << m;
    e.dat = dat;
    sb_q.push_back(e);
    ret_q.push_back(dat);
    step();
    m_rd_avalid[m] = 1'b0;
  endtask

  // Controller returns the next word; owning master must see it
  task automatic ret_one(input string tag);
    rexp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      c_rd_data = ret_q.pop_front();
      c_rd_valid = 1'b1;
      m_rd_ready = '1;
      #1;
      chk({tag, "_vld"}, 32'(m_rd_valid), 32'(e.vld));
      chk({tag, "_dat"}, 32'(m_rd_data), 32'({NM{e.dat}}));
      chk({tag, "_crdy"}, 32'(c_rd_ready), 32'(1));
      step();
      c_rd_valid = 1'b0;
    end
  endtask

  initial begin
    logic bad;
    logic found;
    int   got;
    int   last_w;
    int   slot;
    int   wrn;

    m_wr_data = '0;
    m_wr_addr = '0;
    m_rd_addr = '0;
    do_reset();
    #1;

    // Reset state
    chk("rst_c_wr_valid", 32'(c_wr_valid), 32'(0));
    chk("rst_c_rd_avalid", 32'(c_rd_avalid), 32'(0));
    chk("rst_c_wr_addr", 32'(c_wr_addr), 32'(0));
    chk("rst_arb_busy", 32'(arb_busy), 32'(0));
    chk("rst_err_orphan", 32'(err_orphan), 32'(0));
    chk("rst_m_readies", 32'({m_wr_ready, m_rd_aready, m_rd_valid}), 32'(0));
    chk("rst_rr_ptr", 32'(dut.r_rr_ptr), 32'(0));
    chk("rst_fifo_count", 32'(dut.u_idfifo.r_count), 32'(0));

    // Init gating
    m_wr_addr[0*AW +: AW] = 24'h000010;
    m_wr_addr[1*AW +: AW] = 24'h000020;
    m_wr_data[0*DW +: DW] = 16'h1111;
    m_wr_data[1*DW +: DW] = 16'h2222;
    m_wr_valid = 2'b11;
    bad = 1'b0;
    repeat (20) begin
      step();
      if (c_wr_valid || arb_busy) bad = 1'b1;
    end
    chk("init_gate_no_grant", 32'(bad), 32'(0));
    sdram_init_done = 1'b1;
    step();
    chk("init_fwd_valid", 32'(c_wr_valid), 32'(1));
    chk("init_fwd_addr", 32'(c_wr_addr), 32'h10);
    chk("init_fwd_data", 32'(c_wr_data), 32'h1111);
    chk("init_busy", 32'(arb_busy), 32'(1));
    chk("init_wr_ready_held", 32'(m_wr_ready), 32'(0));
    c_wr_ready = 1'b1;
    #1;
    chk("init_wr_ready_m0", 32'(m_wr_ready), 32'b01);
    step();
    m_wr_valid = '0;
    c_wr_ready = 1'b0;
    #1;
    chk("init_after_hs_idle", 32'(arb_busy), 32'(0));
    chk("init_rr_ptr", 32'(dut.r_rr_ptr), 32'(1));

    // Round-robin over all four slots
    do_reset();
    sdram_init_done = 1'b1;
    m_wr_valid = 2'b11;
    m_rd_avalid = 2'b11;
    c_wr_ready = 1'b1;
    c_rd_aready = 1'b1;
    slot_q = '{0, 1, 2, 3, 0};
    got = 0;
    last_w = -1;
    for (int w = 0; w < 16 && got < 5; w++) begin
      step();
      slot = -1;
      if (c_wr_valid && c_wr_ready) slot = m_wr_ready[1] ? 2 : 0;
      else if (c_rd_avalid && c_rd_aready) slot = m_rd_aready[1] ? 3 : 1;
      if (slot >= 0) begin
        chk("rr_single_ready", 32'($countones({m_wr_ready, m_rd_aready})), 32'(1));
        chk("rr_slot", 32'(slot), 32'(slot_q.pop_front()));
        if (last_w >= 0) chk("rr_gap", 32'(w - last_w), 32'(2));
        last_w = w;
        got++;
      end
    end
    chk("rr_count", 32'(got), 32'(5));
    idle_inputs();

    // Read return routing with backpressure
    do_reset();
    sdram_init_done = 1'b1;
    issue_rd(1, 24'h000100, 16'hAAAA, "rt_m1");
    issue_rd(0, 24'h000200, 16'hBBBB, "rt_m0");
    chk("rt_fifo_count", 32'(dut.u_idfifo.r_count), 32'(2));
    c_rd_data = ret_q[0];
    c_rd_valid = 1'b1;
    m_rd_ready = 2'b01;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("rt_bp_crdy", 32'(c_rd_ready), 32'(0));
      chk("rt_bp_vld", 32'(m_rd_valid), 32'b10);
      step();
    end
    chk("rt_bp_count", 32'(dut.u_idfifo.r_count), 32'(2));
    ret_one("rt_ret0");
    ret_one("rt_ret1");
    chk("rt_empty", 32'(dut.u_idfifo.r_count), 32'(0));

    // FIFO full: reads blocked, writes continue
    do_reset();
    sdram_init_done = 1'b1;
    m_rd_addr[0*AW +: AW] = 24'h000300;
    m_rd_avalid[0] = 1'b1;
    c_rd_aready = 1'b1;
    got = 0;
    for (int w = 0; w < 20 && got < 4; w++) begin
      step();
      if (c_rd_avalid && m_rd_aready[0]) begin
        sb_q.push_back('{vld: 2'b01, dat: 16'h1000 + 16'(got)});
        ret_q.push_back(16'h1000 + 16'(got));
        got++;
      end
    end
    chk("full_reads_issued", 32'(got), 32'(4));
    step();
    m_wr_addr[0*AW +: AW] = 24'h000500;
    m_wr_valid = 2'b01;
    c_wr_ready = 1'b1;
    bad = 1'b0;
    wrn = 0;
    for (int w = 0; w < 8; w++) begin
      step();
      if (c_rd_avalid) bad = 1'b1;
      if (c_wr_valid && m_wr_ready[0]) wrn++;
    end
    chk("full_read_blocked", 32'(bad), 32'(0));
    chk("full_writes_proceed", 32'(wrn >= 2), 32'(1));
    chk("full_count", 32'(dut.u_idfifo.r_count), 32'(4));
    m_wr_valid = '0;
    c_wr_ready = 1'b0;
    ret_one("full_ret0");
    found = 1'b0;
    for (int t = 0; t < 2; t++) begin
      if (c_rd_avalid && m_rd_aready[0]) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("full_5th_granted", 32'(found), 32'(1));
    sb_q.push_back('{vld: 2'b01, dat: 16'h1004});
    ret_q.push_back(16'h1004);
    step();
    m_rd_avalid = '0;
    for (int k = 0; k < 4; k++) ret_one("full_drain");
    chk("full_drained", 32'(dut.u_idfifo.r_count), 32'(0));

    // Orphan data with FIFO empty
    c_rd_data = 16'hDEAD;
    c_rd_valid = 1'b1;
    m_rd_ready = '0;
    #1;
    chk("orph_crdy", 32'(c_rd_ready), 32'(1));
    chk("orph_no_mvld", 32'(m_rd_valid), 32'(0));
    chk("orph_flag_pre", 32'(err_orphan), 32'(0));
    step();
    c_rd_valid = 1'b0;
    #1;
    chk("orph_flag_set", 32'(err_orphan), 32'(1));
    repeat (3) step();
    chk("orph_flag_sticky", 32'(err_orphan), 32'(1));
    do_reset();
    #1;
    chk("orph_flag_cleared", 32'(err_orphan), 32'(0));

    // Reset during a stalled grant
    sdram_init_done = 1'b1;
    issue_rd(0, 24'h000400, 16'hCCCC, "mr_rd");
    m_wr_addr[0*AW +: AW] = 24'h000600;
    m_wr_valid = 2'b01;
    c_wr_ready = 1'b0;
    step();
    chk("mr_busy", 32'(arb_busy), 32'(1));
    chk("mr_wr_valid", 32'(c_wr_valid), 32'(1));
    chk("mr_rr_pre", 32'(dut.r_rr_ptr), 32'(2));
    chk("mr_count_pre", 32'(dut.u_idfifo.r_count), 32'(1));
    rst = 1'b1;
    step();
    chk("mr_c_wr_valid", 32'(c_wr_valid), 32'(0));
    chk("mr_c_rd_avalid", 32'(c_rd_avalid), 32'(0));
    chk("mr_busy_post", 32'(arb_busy), 32'(0));
    chk("mr_rr_ptr", 32'(dut.r_rr_ptr), 32'(0));
    chk("mr_count", 32'(dut.u_idfifo.r_count), 32'(0));
    rst = 1'b0;
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
